// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and lane extraction helper for the 16:1 mux
package mux_pkg;

  localparam int N_LANES    = 16;
  localparam int SEL_W      = 4;
  localparam int LANE_W_MAX = 64;

  // Callers zero-pad their packed bus to N_LANES*LANE_W_MAX bits and cast the result to their width.
  function automatic logic [LANE_W_MAX-1:0] lane_of(
    input logic [N_LANES*LANE_W_MAX-1:0] bus,
    input int unsigned                   idx,
    input int unsigned                   w
  );
    logic [LANE_W_MAX-1:0] mask;
    mask = (LANE_W_MAX'(1) << w) - LANE_W_MAX'(1);
    return LANE_W_MAX'(bus >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/mux4_to_1.sv
// rtl/mux4_to_1.sv - combinational 4:1 lane selector, leaf of the 16:1 tree
module mux4_to_1 #(
  parameter int DATA_W = 1
) (
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  input  logic [DATA_W-1:0] d3_i,
  input  logic [1:0]        sel_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    case (sel_i)
      2'd0: y_o = d0_i;
      2'd1: y_o = d1_i;
      2'd2: y_o = d2_i;
      2'd3: y_o = d3_i;
    endcase
  end

endmodule

// File: rtl/mux16_to_1.sv
// rtl/mux16_to_1.sv - registered 16:1 mux built from a two-level tree of 4:1 selectors
module mux16_to_1
  import mux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_LANES*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid
);

  logic [N_LANES*LANE_W_MAX-1:0] bus_pad;
  logic [DATA_W-1:0]             lane [N_LANES];
  logic [DATA_W-1:0]             grp  [4];
  logic [DATA_W-1:0]             sel_data;
  logic [DATA_W-1:0]             out_data_d, out_data_q;
  logic                          out_valid_d, out_valid_q;

  always_comb begin
    bus_pad                         = '0;
    bus_pad[N_LANES*DATA_W-1:0]     = in_data;
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign lane[k] = DATA_W'(lane_of(bus_pad, k, DATA_W));
  end

  // Level 1: sel[1:0] picks within each group of four lanes.
  for (genvar g = 0; g < 4; g++) begin : g_l1
    mux4_to_1 #(.DATA_W(DATA_W)) u_l1 (
      .d0_i  (lane[4*g]),
      .d1_i  (lane[4*g+1]),
      .d2_i  (lane[4*g+2]),
      .d3_i  (lane[4*g+3]),
      .sel_i (sel[1:0]),
      .y_o   (grp[g])
    );
  end

  mux4_to_1 #(.DATA_W(DATA_W)) u_l2 (
    .d0_i  (grp[0]),
    .d1_i  (grp[1]),
    .d2_i  (grp[2]),
    .d3_i  (grp[3]),
    .sel_i (sel[3:2]),
    .y_o   (sel_data)
  );

  // Data holds on invalid cycles so the output never toggles without a valid beat.
  always_comb begin
    out_valid_d = in_valid;
    out_data_d  = in_valid ? sel_data : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux16_to_1.sv
// tb/tb_mux16_to_1.sv - randomized and directed bench for mux16_to_1 at DATA_W=1 and DATA_W=8
module tb_mux16_to_1;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  d1;
  logic [3:0]   s1;
  logic         v1;
  logic [0:0]   o1;
  logic         ov1;
  logic [127:0] d8;
  logic [3:0]   s8;
  logic         v8;
  logic [7:0]   o8;
  logic         ov8;

  logic [7:0]   lanes8 [16];
  logic         e1_d, e1_v, e8_v;
  logic [7:0]   e8_d;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  mux16_to_1 #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(d1), .sel(s1), .in_valid(v1),
    .out_data(o1), .out_valid(ov1)
  );

  mux16_to_1 #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_data(d8), .sel(s8), .in_valid(v8),
    .out_data(o8), .out_valid(ov8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pack8();
    for (int k = 0; k < 16; k++) d8[k*8 +: 8] = lanes8[k];
  endtask

  task automatic rand8();
    for (int k = 0; k < 16; k++) lanes8[k] = 8'($urandom);
    pack8();
    s8 = 4'($urandom_range(0, 15));
    v8 = 1'($urandom);
  endtask

  // Reference: a lane is the sel-th DATA_W chunk; hold data and drop valid when not qualified.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      e1_d = 1'b0; e1_v = 1'b0; e8_d = 8'h00; e8_v = 1'b0;
    end else begin
      e1_v = v1;
      if (v1) e1_d = 1'((d1 >> s1) & 16'd1);
      e8_v = v8;
      if (v8) e8_d = lanes8[s8];
    end
    @(negedge clk);
    chk("w1_data",  64'(o1),  64'(e1_d));
    chk("w1_valid", 64'(ov1), 64'(e1_v));
    chk("w8_data",  64'(o8),  64'(e8_d));
    chk("w8_valid", 64'(ov8), 64'(e8_v));
  endtask

  initial begin
    rst = 1'b1; v1 = 1'b1; d1 = 16'hFFFF; s1 = 4'd5;
    rand8();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_data", 64'(o1), 64'd0);
      chk("rst_valid", 64'(ov1), 64'd0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_data", 64'(o1), 64'd1);

    d1 = 16'b1010101010101010;
    for (int k = 0; k < 16; k++) begin
      s1 = 4'(k); rand8(); tick();
      chk("sweep", 64'(o1), 64'(k % 2));
    end

    for (int k = 0; k < 16; k++) begin
      s1 = 4'(k); rst = (k == 9); rand8(); tick();
      if (k == 9) chk("mid_rst_valid", 64'(ov1), 64'd0);
    end
    rst = 1'b0;
    s1 = 4'd0; tick();

    for (int k = 0; k < 16; k++) begin
      d1 = 16'd1 << k; s1 = 4'(k); rand8(); tick();
      chk("walk_hit", 64'(o1), 64'd1);
    end
    for (int k = 0; k < 16; k++) begin
      d1 = 16'd1 << k; s1 = 4'((k + 1) % 16); rand8(); tick();
      chk("walk_miss", 64'(o1), 64'd0);
    end

    d1 = 16'h0008; s1 = 4'd3; v1 = 1'b1; tick();
    v1 = 1'b0; s1 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_data", 64'(o1), 64'd1);
    end

    for (int k = 0; k < 16; k++) lanes8[k] = 8'h10 + 8'(k);
    pack8();
    v8 = 1'b1;
    s8 = 4'h0; tick(); chk("wide_0", 64'(o8), 64'h10);
    s8 = 4'h7; tick(); chk("wide_7", 64'(o8), 64'h17);
    s8 = 4'hF; tick(); chk("wide_f", 64'(o8), 64'h1F);

    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 19) == 0);
      d1  = 16'($urandom);
      s1  = 4'($urandom_range(0, 15));
      v1  = 1'($urandom);
      rand8();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux16_to_1.md
Name: mux16_to_1

Overview:
Registered 16-to-1 multiplexer. It selects one of sixteen DATA_W-bit lanes from a packed input bus using a 4-bit select. The chosen lane is presented on a registered output one clock later, together with a valid flag. It is a generic selection primitive used wherever a datapath must pick one of sixteen sources; with DATA_W=1 it is a single-bit 16:1 mux.

Parameters:
DATA_W, 1, width in bits of each of the 16 input lanes and of the output

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_data  input  16*DATA_W  packed lanes; lane k = in_data[k*DATA_W +: DATA_W], lane 0 at LSBs
sel  input  4  lane index 0..15, unsigned
in_valid  input  1  qualifies in_data/sel this cycle
out_data  output  DATA_W  registered selected lane
out_valid  output  1  registered copy of in_valid

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, out_data is set to 0 and out_valid to 0. rst has priority over all other inputs.
- Selection is purely combinational: lane[sel]. All 16 sel codes are legal and there is no default or out-of-range case.
- Latency is exactly 1 cycle. On a clk edge with rst=0 and in_valid=1: out_data <= lane[sel], out_valid <= 1.
- On a clk edge with rst=0 and in_valid=0: out_valid <= 0 and out_data holds its previous value. The output does not toggle on invalid cycles.
- There is no backpressure. A new selection can be accepted every cycle, and back-to-back sel changes give back-to-back outputs.
- sel and in_data are sampled only at the clk edge. Changes between edges have no effect on the outputs.
- If rst is asserted mid-stream, the next edge clears both outputs. The first valid input after rst drops appears one cycle after it is sampled.
- There is no internal state apart from the out_data and out_valid registers.
- Width rule: out_data width equals DATA_W. No sign or arithmetic interpretation is applied.

Decomposition:
- Shared package mux_pkg holds:
  - localparam N_LANES = 16
  - localparam SEL_W = 4
  - a function lane_of(bus, idx) that extracts a DATA_W slice
- Sub-module mux4_to_1 (parameter DATA_W; four lane inputs, 2-bit sel, combinational out).
  - Five instances form a two-level tree.
  - Level 1: four instances select with sel[1:0] over lanes 4g..4g+3, g = 0..3.
  - Level 2: one instance selects with sel[3:2].
- The top level adds the output register stage, the valid register, and reset handling.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, in_data=16'hFFFF, sel=5 -> out_data=0 and out_valid=0 throughout; out_data=1 one cycle after rst deasserts.
- Sweep, DATA_W=1: in_data=16'b1010101010101010, in_valid=1, sel stepping 0..15 one per cycle -> out_data sequence 0,1,0,1,...,1, each delayed 1 cycle; out_valid=1 continuously.
- Walking one, DATA_W=1: in_data=1<<k with sel=k, for k=0..15 -> out_data=1 each cycle. Then the same in_data with sel=(k+1)%16 -> out_data=0 each cycle.
- Hold on invalid: load sel=3 with in_data=16'h0008 (out_data=1), then in_valid=0 with sel=0 for 3 cycles -> out_data stays 1, out_valid=0.
- Wide lanes, DATA_W=8: lane k = 8'h10+k, sel=0x0, 0x7, 0xF -> out_data=8'h10, 8'h17, 8'h1F, each one cycle later.
- Reset mid-stream: during the sweep, assert rst at sel=9 for 1 cycle -> outputs are 0/0 on that edge; the sweep resumes with correct lane values one cycle after rst falls.
